ldpc_dvb_dec_obuf: RTL

LDPC_DVB_DEC_OBUF -- requirements
Module: ldpc_dvb_dec_obuf

---
 rtl/ldpc_dvb_pkg.sv | 26 ++
 rtl/ldpc_dvb_dec_obuf_if.sv | 37 +++
 rtl/ldpc_dvb_dec_obuf_fifo.sv | 47 ++++
 rtl/ldpc_dvb_dec_obuf.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ldpc_dvb_pkg.sv
// Shared LDPC DVB constants plus the decoder output-buffer entry and framing types.
package ldpc_dvb_pkg;

    localparam int unsigned LDPC_DVB_DAT_W   = 8;
    localparam int unsigned LDPC_DVB_TAG_W   = 8;
    localparam int unsigned LDPC_DVB_ERR_W   = 16;
    localparam int unsigned LDPC_DVB_NITER_W = 8;
    localparam int unsigned LDPC_DVB_STAT_W  = 32;

    // One buffered output word with its framing and decoder status.
    typedef struct packed {
        logic                        sop;
        logic                        eop;
        logic [LDPC_DVB_DAT_W-1:0]   dat;
        logic [LDPC_DVB_TAG_W-1:0]   tag;
        logic                        decfail;
        logic [LDPC_DVB_ERR_W-1:0]   err;
        logic [LDPC_DVB_NITER_W-1:0] niter;
    } obuf_entry_t;

    typedef enum logic {
        FRM_IDLE  = 1'b0,
        FRM_FRAME = 1'b1
    } obuf_frm_t;

endpackage

// File: rtl/ldpc_dvb_dec_obuf_if.sv
// Upstream (credit request + word) and downstream (valid/ready) buses of the decoder output buffer.
interface ldpc_dvb_dec_obuf_if #(
    parameter int unsigned pDAT_W = 8,
    parameter int unsigned pTAG_W = 8,
    parameter int unsigned pERR_W = 16
);
    logic              ifull;
    logic              oreq;
    logic              isop;
    logic              ieop;
    logic              ival;
    logic [pDAT_W-1:0] idat;
    logic [pTAG_W-1:0] itag;
    logic              idecfail;
    logic [pERR_W-1:0] ierr;
    logic [7:0]        iNiter;

    logic              irdy;
    logic              osop;
    logic              oeop;
    logic              oval;
    logic [pDAT_W-1:0] odat;
    logic [pTAG_W-1:0] otag;
    logic              odecfail;
    logic [pERR_W-1:0] oerr;
    logic [7:0]        oNiter;

    modport slave (
        input  ifull, isop, ieop, ival, idat, itag, idecfail, ierr, iNiter, irdy,
        output oreq, osop, oeop, oval, odat, otag, odecfail, oerr, oNiter
    );

    modport master (
        output ifull, isop, ieop, ival, idat, itag, idecfail, ierr, iNiter, irdy,
        input  oreq, osop, oeop, oval, odat, otag, odecfail, oerr, oNiter
    );
endinterface

// File: rtl/ldpc_dvb_dec_obuf_fifo.sv
// Show-ahead FIFO of obuf entries; head reads as zero while empty.
module ldpc_dvb_dec_obuf_fifo
    import ldpc_dvb_pkg::*;
#(
    parameter int unsigned pDEPTH_W = 4
) (
    input  logic        iclk,
    input  logic        ireset,
    input  logic        wr,
    input  obuf_entry_t wdat,
    input  logic        rd,
    output obuf_entry_t head,
    output logic        empty,
    output logic        full
);
    localparam int unsigned DEPTH = 2 ** pDEPTH_W;
    localparam int unsigned PTR_W = pDEPTH_W + 1;

    obuf_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             pop_c;
    logic             push_c;

    assign empty  = (wptr == rptr);
    assign full   = (wptr[pDEPTH_W] != rptr[pDEPTH_W]) &&
                    (wptr[pDEPTH_W-1:0] == rptr[pDEPTH_W-1:0]);
    assign pop_c  = rd & ~empty;
    // A pop frees the slot this same edge, so a full FIFO still accepts a write alongside it.
    assign push_c = wr & (~full | pop_c);

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_c) wptr <= wptr + PTR_W'(1);
            if (pop_c)  rptr <= rptr + PTR_W'(1);
        end
    end

    always_ff @(posedge iclk) begin
        if (push_c) mem[wptr[pDEPTH_W-1:0]] <= wdat;
    end

    assign head = empty ? '0 : mem[rptr[pDEPTH_W-1:0]];
endmodule

// File: rtl/ldpc_dvb_dec_obuf.sv
// LDPC DVB decoder output buffer: credit-based upstream pull, show-ahead FIFO, framing check.
// Define LDPC_DVB_DEC_OBUF_STAT_EN to build the delivered-frame / failed-frame counters.
module ldpc_dvb_dec_obuf
    import ldpc_dvb_pkg::*;
#(
    parameter int unsigned pDAT_W   = LDPC_DVB_DAT_W,
    parameter int unsigned pTAG_W   = LDPC_DVB_TAG_W,
    parameter int unsigned pERR_W   = LDPC_DVB_ERR_W,
    parameter int unsigned pDEPTH_W = 4,
    parameter int unsigned pSTAT_W  = LDPC_DVB_STAT_W
) (
    input  logic                iclk,
    input  logic                ireset,
    input  logic                iclkena,
    input  logic                iclr,
    ldpc_dvb_dec_obuf_if.slave  bus,
    output logic                oovf,
    output logic                oframe_err,
    output logic [pSTAT_W-1:0]  oframe_cnt,
    output logic [pSTAT_W-1:0]  ofail_cnt
);
    localparam int unsigned      CRD_W = pDEPTH_W + 1;
    localparam logic [CRD_W-1:0] DEPTH = CRD_W'(2 ** pDEPTH_W);

    obuf_entry_t      wr_entry;
    obuf_entry_t      head;
    logic             empty;
    logic             full;
    logic             wr_c;
    logic             pop_c;
    logic             req_c;
    logic             dec_c;
    logic             ovf_set_c;
    logic             ferr_set_c;
    logic [CRD_W-1:0] credit;
    obuf_frm_t        state;
    obuf_frm_t        state_nxt;

    always_comb begin
        wr_entry.sop     = bus.isop;
        wr_entry.eop     = bus.ieop;
        wr_entry.dat     = LDPC_DVB_DAT_W'(bus.idat);
        wr_entry.tag     = LDPC_DVB_TAG_W'(bus.itag);
        wr_entry.decfail = bus.idecfail;
        wr_entry.err     = LDPC_DVB_ERR_W'(bus.ierr);
        wr_entry.niter   = LDPC_DVB_NITER_W'(bus.iNiter);
    end

    assign wr_c      = bus.ival & iclkena;
    assign pop_c     = ~empty & bus.irdy & iclkena;
    assign ovf_set_c = wr_c & full & ~pop_c;
    // Gated by reset too so no request escapes while the credit count is being cleared.
    assign req_c     = bus.ifull & iclkena & ireset & (credit < DEPTH);
    // Words written after a reset carry no credit; keep the count from wrapping below zero.
    assign dec_c     = pop_c & (credit != '0);

    ldpc_dvb_dec_obuf_fifo #(.pDEPTH_W(pDEPTH_W)) u_fifo (
        .iclk   (iclk),
        .ireset (ireset),
        .wr     (wr_c),
        .wdat   (wr_entry),
        .rd     (pop_c),
        .head   (head),
        .empty  (empty),
        .full   (full)
    );

    assign bus.oreq     = req_c;
    assign bus.oval     = ~empty;
    assign bus.osop     = head.sop;
    assign bus.oeop     = head.eop;
    assign bus.odat     = pDAT_W'(head.dat);
    assign bus.otag     = pTAG_W'(head.tag);
    assign bus.odecfail = head.decfail;
    assign bus.oerr     = pERR_W'(head.err);
    assign bus.oNiter   = 8'(head.niter);

    // Credits = words stored + requests outstanding.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            credit <= '0;
        end else if (req_c & ~dec_c) begin
            credit <= credit + CRD_W'(1);
        end else if (~req_c & dec_c) begin
            credit <= credit - CRD_W'(1);
        end
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) state <= FRM_IDLE;
        else if (iclkena) state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ferr_set_c = 1'b0;
        if (bus.ival) begin
            case (state)
                FRM_IDLE: begin
                    if (!bus.isop)      ferr_set_c = 1'b1;
                    else if (!bus.ieop) state_nxt  = FRM_FRAME;
                end
                FRM_FRAME: begin
                    if (bus.isop) ferr_set_c = 1'b1;
                    if (bus.ieop) state_nxt  = FRM_IDLE;
                end
                default: state_nxt = FRM_IDLE;
            endcase
        end
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            oovf       <= 1'b0;
            oframe_err <= 1'b0;
        end else if (iclkena) begin
            if (iclr) begin
                oovf       <= 1'b0;
                oframe_err <= 1'b0;
            end else begin
                if (ovf_set_c)  oovf       <= 1'b1;
                if (ferr_set_c) oframe_err <= 1'b1;
            end
        end
    end

`ifdef LDPC_DVB_DEC_OBUF_STAT_EN
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            oframe_cnt <= '0;
            ofail_cnt  <= '0;
        end else if (iclkena) begin
            if (iclr) begin
                oframe_cnt <= '0;
                ofail_cnt  <= '0;
            end else if (pop_c & head.eop) begin
                oframe_cnt <= oframe_cnt + pSTAT_W'(1);
                if (head.decfail) ofail_cnt <= ofail_cnt + pSTAT_W'(1);
            end
        end
    end
`else
    assign oframe_cnt = '0;
    assign ofail_cnt  = '0;
`endif
endmodule
